// File: rtl/cmul_addsub_sched.sv
// cmul_addsub_sched: finishes a complex product from four signed partial
// products by running two passes through one shared add/sub datapath.
//   normal    (conj=0): re = ac - bd, im = ad + bc
//   conjugate (conj=1): re = ac + bd, im = bc - ad
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand handshake (conj, ac, bd, ad, bc)
//   out_valid/out_ready     result handshake (re, im, ov_re, ov_im)
//   busy                    high whenever the sequencer is not idle
// Parameters:
//   SAT_EN  1 = clamp on signed overflow, 0 = two's-complement wrap
//   W       datapath width, must be 32
module cmul_addsub_sched #(
  parameter bit          SAT_EN = 1'b1,
  parameter int unsigned W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         conj,
  input  logic [W-1:0] ac,
  input  logic [W-1:0] bd,
  input  logic [W-1:0] ad,
  input  logic [W-1:0] bc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] re,
  output logic [W-1:0] im,
  output logic         ov_re,
  output logic         ov_im,
  output logic         busy
);

  localparam int unsigned BLK  = 4;
  localparam int unsigned NBLK = W / BLK;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  // Width is tied to the shared adder; reject anything else at elaboration.
  if (W != 32) begin : g_w_check
    $error("cmul_addsub_sched: W must be 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_RE, S_IM, S_HOLD} state_t;

  state_t       state;
  logic [W-1:0] ac_q, bd_q, ad_q, bc_q;
  logic         conj_q;
  logic         accept_c;

  logic [W-1:0] add_a, add_b;
  logic         add_sub;
  logic [W-1:0] bx, g, p, c, add_s;
  logic         blk_g, blk_p;
  logic         ov_c;
  logic [W-1:0] res_c;

  // Retiring a held result and accepting new operands can share one edge.
  assign in_ready = (state == S_IDLE) | ((state == S_HOLD) & out_ready);
  assign accept_c = in_valid & in_ready;

  // Adder operand steering, from state and captured operands only.
  always_comb begin : adder_ctrl
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (state)
      S_RE: begin
        add_a   = ac_q;
        add_b   = bd_q;
        add_sub = ~conj_q;
      end
      S_IM: begin
        if (conj_q) begin
          add_a   = bc_q;
          add_b   = ad_q;
          add_sub = 1'b1;
        end else begin
          add_a   = ad_q;
          add_b   = bc_q;
          add_sub = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Add/sub with 4-bit carry-lookahead blocks; subtract is a + ~b + 1.
  always_comb begin : adder
    bx    = add_b ^ {W{add_sub}};
    g     = add_a & bx;
    p     = add_a ^ bx;
    c     = '0;
    c[0]  = add_sub;
    blk_g = 1'b0;
    blk_p = 1'b1;
    for (int k = 0; k < int'(NBLK); k++) begin
      blk_g = 1'b0;
      blk_p = 1'b1;
      for (int j = 0; j < int'(BLK); j++) begin
        blk_g = g[BLK*k+j] | (p[BLK*k+j] & blk_g);
        blk_p = blk_p & p[BLK*k+j];
      end
      for (int j = 0; j < int'(BLK) - 1; j++) begin
        c[BLK*k+j+1] = g[BLK*k+j] | (p[BLK*k+j] & c[BLK*k+j]);
      end
      if (k < int'(NBLK) - 1) begin
        c[BLK*(k+1)] = blk_g | (blk_p & c[BLK*k]);
      end
    end
    add_s = p ^ c;
  end

  // Signed overflow from operand/result sign bits, then optional clamp.
  always_comb begin : ovf_sat
    if (add_sub) begin
      ov_c = (add_a[W-1] != add_b[W-1]) & (add_s[W-1] != add_a[W-1]);
    end else begin
      ov_c = (add_a[W-1] == add_b[W-1]) & (add_s[W-1] != add_a[W-1]);
    end
    if (SAT_EN && ov_c) begin
      res_c = add_a[W-1] ? MIN_NEG : MAX_POS;
    end else begin
      res_c = add_s;
    end
  end

  // Sequencer: IDLE -> RE -> IM -> HOLD, with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ac_q      <= '0;
      bd_q      <= '0;
      ad_q      <= '0;
      bc_q      <= '0;
      conj_q    <= 1'b0;
      re        <= '0;
      im        <= '0;
      ov_re     <= 1'b0;
      ov_im     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (accept_c) begin
        ac_q   <= ac;
        bd_q   <= bd;
        ad_q   <= ad;
        bc_q   <= bc;
        conj_q <= conj;
      end
      unique case (state)
        S_IDLE: begin
          if (accept_c) begin
            state <= S_RE;
            busy  <= 1'b1;
          end
        end
        S_RE: begin
          re    <= res_c;
          ov_re <= ov_c;
          state <= S_IM;
        end
        S_IM: begin
          im        <= res_c;
          ov_im     <= ov_c;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              state <= S_RE;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmul_addsub_sched.sv
// Bench for cmul_addsub_sched: a saturating and a wrapping instance share
// all inputs; expected results come from constants and a wide-integer model.
module tb_cmul_addsub_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, conj, out_ready;
  logic [31:0] ac, bd, ad, bc;

  logic        in_ready_s, out_valid_s, ov_re_s, ov_im_s, busy_s;
  logic [31:0] re_s, im_s;
  logic        in_ready_w, out_valid_w, ov_re_w, ov_im_w, busy_w;
  logic [31:0] re_w, im_w;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] re_s, im_s, re_w, im_w;
    logic        ov_re, ov_im;
  } exp_t;

  typedef struct {
    logic [31:0] ac, bd, ad, bc;
    logic        conj;
    logic [31:0] re_s, im_s, re_w, im_w;
    logic        ov_re, ov_im;
  } dvec_t;

  exp_t sb[$];

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  always #5 clk = ~clk;

  cmul_addsub_sched #(.SAT_EN(1'b1), .W(32)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .conj(conj), .ac(ac), .bd(bd), .ad(ad), .bc(bc),
    .out_valid(out_valid_s), .out_ready(out_ready), .re(re_s), .im(im_s),
    .ov_re(ov_re_s), .ov_im(ov_im_s), .busy(busy_s)
  );

  cmul_addsub_sched #(.SAT_EN(1'b0), .W(32)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .conj(conj), .ac(ac), .bd(bd), .ad(ad), .bc(bc),
    .out_valid(out_valid_w), .out_ready(out_ready), .re(re_w), .im(im_w),
    .ov_re(ov_re_w), .ov_im(ov_im_w), .busy(busy_w)
  );

  // Reference: exact sum in 64 bits, then wrap or clamp.
  function automatic exp_t model(logic [31:0] a_c, b_d, a_d, b_c, logic cj);
    exp_t   e;
    longint x, y;
    x = cj ? (longint'($signed(a_c)) + longint'($signed(b_d)))
           : (longint'($signed(a_c)) - longint'($signed(b_d)));
    y = cj ? (longint'($signed(b_c)) - longint'($signed(a_d)))
           : (longint'($signed(a_d)) + longint'($signed(b_c)));
    e.ov_re = (x > MAXV) || (x < MINV);
    e.ov_im = (y > MAXV) || (y < MINV);
    e.re_w  = x[31:0];
    e.im_w  = y[31:0];
    e.re_s  = (x > MAXV) ? 32'h7FFF_FFFF : (x < MINV) ? 32'h8000_0000 : x[31:0];
    e.im_s  = (y > MAXV) ? 32'h7FFF_FFFF : (y < MINV) ? 32'h8000_0000 : y[31:0];
    return e;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    in_valid = 1'b0; conj = 1'b0; out_ready = 1'b0;
    ac = '0; bd = '0; ad = '0; bc = '0;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({re_s, im_s, ov_re_s, ov_im_s, out_valid_s, busy_s, in_ready_s} !==
        {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_sat: got re=%h im=%h ov=%b%b ov_valid=%b busy=%b rdy=%b, want zeros rdy=1",
               re_s, im_s, ov_re_s, ov_im_s, out_valid_s, busy_s, in_ready_s);
    end
    n_vec++;
    if ({re_w, im_w, ov_re_w, ov_im_w, out_valid_w, busy_w, in_ready_w} !==
        {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_wrap: got re=%h im=%h ov=%b%b valid=%b busy=%b rdy=%b, want zeros rdy=1",
               re_w, im_w, ov_re_w, ov_im_w, out_valid_w, busy_w, in_ready_w);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    dvec_t tbl[4];
    tbl[0] = '{ac: 32'd100, bd: 32'd30, ad: 32'd7, bc: 32'd5, conj: 1'b0,
               re_s: 32'd70, im_s: 32'd12, re_w: 32'd70, im_w: 32'd12, ov_re: 1'b0, ov_im: 1'b0};
    tbl[1] = '{ac: 32'd100, bd: 32'd30, ad: 32'd7, bc: 32'd5, conj: 1'b1,
               re_s: 32'd130, im_s: 32'hFFFF_FFFE, re_w: 32'd130, im_w: 32'hFFFF_FFFE, ov_re: 1'b0, ov_im: 1'b0};
    tbl[2] = '{ac: 32'h7FFF_FFFF, bd: 32'hFFFF_FFFF, ad: 32'h8000_0000, bc: 32'h8000_0000, conj: 1'b0,
               re_s: 32'h7FFF_FFFF, im_s: 32'h8000_0000, re_w: 32'h8000_0000, im_w: 32'h0000_0000,
               ov_re: 1'b1, ov_im: 1'b1};
    tbl[3] = '{ac: 32'h8000_0000, bd: 32'd1, ad: 32'h7FFF_FFFF, bc: 32'd1, conj: 1'b0,
               re_s: 32'h8000_0000, im_s: 32'h7FFF_FFFF, re_w: 32'h7FFF_FFFF, im_w: 32'h8000_0000,
               ov_re: 1'b1, ov_im: 1'b1};
    foreach (tbl[i]) begin
      in_valid = 1'b1; out_ready = 1'b1; conj = tbl[i].conj;
      ac = tbl[i].ac; bd = tbl[i].bd; ad = tbl[i].ad; bc = tbl[i].bc;
      @(negedge clk);
      n_vec++;
      if ({in_ready_s, in_ready_w} !== 2'b11) begin
        n_err++;
        $display("FAIL dir%0d_idle_ready: got %b, want 11", i, {in_ready_s, in_ready_w});
      end
      @(posedge clk); #1;
      // Operand changes after the accept edge must not matter.
      in_valid = 1'b0; conj = ~conj;
      ac = $urandom; bd = $urandom; ad = $urandom; bc = $urandom;
      n_vec++;
      if ({out_valid_s, busy_s} !== 2'b01) begin
        n_err++;
        $display("FAIL dir%0d_re_state: got valid/busy=%b, want 01", i, {out_valid_s, busy_s});
      end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid_s !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_im_state: got valid=%b, want 0", i, out_valid_s);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid_s, re_s, im_s, ov_re_s, ov_im_s} !==
          {1'b1, tbl[i].re_s, tbl[i].im_s, tbl[i].ov_re, tbl[i].ov_im}) begin
        n_err++;
        $display("FAIL dir%0d_sat: got v=%b re=%h im=%h ov=%b%b, want v=1 re=%h im=%h ov=%b%b", i,
                 out_valid_s, re_s, im_s, ov_re_s, ov_im_s,
                 tbl[i].re_s, tbl[i].im_s, tbl[i].ov_re, tbl[i].ov_im);
      end
      n_vec++;
      if ({out_valid_w, re_w, im_w, ov_re_w, ov_im_w} !==
          {1'b1, tbl[i].re_w, tbl[i].im_w, tbl[i].ov_re, tbl[i].ov_im}) begin
        n_err++;
        $display("FAIL dir%0d_wrap: got v=%b re=%h im=%h ov=%b%b, want v=1 re=%h im=%h ov=%b%b", i,
                 out_valid_w, re_w, im_w, ov_re_w, ov_im_w,
                 tbl[i].re_w, tbl[i].im_w, tbl[i].ov_re, tbl[i].ov_im);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid_s, busy_s, out_valid_w, busy_w} !== 4'b0000) begin
        n_err++;
        $display("FAIL dir%0d_back_idle: got %b, want 0000", i, {out_valid_s, busy_s, out_valid_w, busy_w});
      end
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; out_ready = 1'b0; conj = 1'b0;
    ac = 32'd100; bd = 32'd30; ad = 32'd7; bc = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      ac = 32'd999; bd = 32'd1; ad = 32'd2; bc = 32'd3;
      @(negedge clk);
      n_vec++;
      if ({out_valid_s, in_ready_s, re_s, im_s, ov_re_s, ov_im_s} !==
          {1'b1, 1'b0, 32'd70, 32'd12, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b re=%h im=%h, want v=1 rdy=0 re=46 im=0c",
                 i, out_valid_s, in_ready_s, re_s, im_s);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1;
    ac = 32'd10; bd = 32'd3; ad = 32'd2; bc = 32'd4;
    @(negedge clk);
    n_vec++;
    if ({in_ready_s, in_ready_w} !== 2'b11) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b, want 11", {in_ready_s, in_ready_w});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid_s, busy_s} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_retire_accept: got valid/busy=%b, want 01", {out_valid_s, busy_s});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid_s, re_s, im_s, ov_re_s, ov_im_s} !== {1'b1, 32'd7, 32'd6, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL bp_next_result: got v=%b re=%h im=%h ov=%b%b, want v=1 re=7 im=6 ov=00",
               out_valid_s, re_s, im_s, ov_re_s, ov_im_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b1; conj = 1'b0;
    ac = 32'd100; bd = 32'd30; ad = 32'd7; bc = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({re_s, im_s, ov_re_s, ov_im_s, out_valid_s, busy_s, in_ready_s} !==
        {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid_async: got re=%h im=%h ov=%b%b valid=%b busy=%b rdy=%b, want zeros rdy=1",
               re_s, im_s, ov_re_s, ov_im_s, out_valid_s, busy_s, in_ready_s);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid_s, busy_s, out_valid_w, busy_w} !== 4'b0000) begin
        n_err++;
        $display("FAIL rst_mid_no_stale%0d: got %b, want 0000", i,
                 {out_valid_s, busy_s, out_valid_w, busy_w});
      end
    end
    in_valid = 1'b1; conj = 1'b1;
    ac = 32'hFFFF_FFFB; bd = 32'd6; ad = 32'd3; bc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid_s, re_s, im_s, ov_re_s, ov_im_s} !== {1'b1, 32'd1, 32'hFFFF_FFF9, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid_fresh: got v=%b re=%h im=%h ov=%b%b, want v=1 re=1 im=fffffff9 ov=00",
               out_valid_s, re_s, im_s, ov_re_s, ov_im_s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int   sent = 0;
    int   cyc  = 0;
    exp_t e;
    while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      conj      = 1'($urandom_range(1));
      ac = rnd_op(); bd = rnd_op(); ad = rnd_op(); bc = rnd_op();
      @(negedge clk);
      if (out_valid_s && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL rnd_unexpected: got a result with no operand set outstanding, want none");
        end else begin
          e = sb.pop_front();
          if ({re_s, im_s, ov_re_s, ov_im_s} !== {e.re_s, e.im_s, e.ov_re, e.ov_im}) begin
            n_err++;
            $display("FAIL rnd_sat: got re=%h im=%h ov=%b%b, want re=%h im=%h ov=%b%b",
                     re_s, im_s, ov_re_s, ov_im_s, e.re_s, e.im_s, e.ov_re, e.ov_im);
          end
          n_vec++;
          if ({out_valid_w, re_w, im_w, ov_re_w, ov_im_w} !== {1'b1, e.re_w, e.im_w, e.ov_re, e.ov_im}) begin
            n_err++;
            $display("FAIL rnd_wrap: got v=%b re=%h im=%h ov=%b%b, want v=1 re=%h im=%h ov=%b%b",
                     out_valid_w, re_w, im_w, ov_re_w, ov_im_w, e.re_w, e.im_w, e.ov_re, e.ov_im);
          end
        end
      end
      if (in_valid && in_ready_s) begin
        sb.push_back(model(ac, bd, ad, bc, conj));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (sent != 1000 || sb.size() != 0) begin
      n_err++;
      $display("FAIL rnd_drain: got sent=%0d outstanding=%0d, want sent=1000 outstanding=0",
               sent, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

endmodule
